cla_nibble_serial_adder_ctrl: RTL
=================================

// Module: cla_nibble_serial_adder_ctrl
//
// PURPOSE
// Sequences one 4-bit carry-look-ahead adder slice over WIDTH-bit operands, one
// nibble per clock, LSB nibble first, chaining carry through a register. Trades
// latency for area when wide adds are infrequent; sits between an operand
// producer and a result consumer, with valid/ready handshakes on both sides.
//
// PARAMETERS
// WIDTH    16   operand/result width in bits; multiple of 4, >= 4
// NIBBLES  WIDTH/4 (localparam)  slice iterations per add
//
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      synchronous reset, active-low
// in_valid   in   1      operand set valid
// in_ready   out  1      controller can accept operands (IDLE only)
// a          in   WIDTH  operand A, sampled at accept
// b          in   WIDTH  operand B, sampled at accept
// cin        in   1      carry-in, sampled at accept
// out_valid  out  1      result valid (DONE only)
// out_ready  in   1      consumer accepts result
// sum        out  WIDTH  registered result
// cout       out  1      registered carry-out
// busy       out  1      high in RUN or DONE
//
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, nibble index=0, carry reg=0, sum=0,
//   cout=0, out_valid=0, busy=0; in_ready=1 from the first edge after release.
// - Reset mid-RUN or mid-DONE aborts; the partial result is discarded.
// - FSM: IDLE -(in_valid&in_ready)-> RUN -(idx==NIBBLES-1)-> DONE
//   -(out_valid&out_ready)-> IDLE.
// - Accept edge: capture a, b, carry_reg<=cin, idx<=0, sum<=0.
// - Each RUN edge: slice computes a[4i+:4]+b[4i+:4]+carry_reg (4-bit CLA:
//   g=a&b, p=a^b, look-ahead carries); sum[4i+:4]<=slice sum; carry_reg<=slice
//   c4; idx<=idx+1. On the last nibble, cout<=c4 and go to DONE.
// - Latency: out_valid rises exactly NIBBLES edges after the accept edge.
// - Result: {cout,sum} == a + b + cin (WIDTH+1-bit exact, no saturation).
// - in_ready=0 in RUN/DONE; in_valid there is ignored; a/b/cin changes after
//   accept have no effect. No same-cycle DONE->accept bypass: a new accept
//   occurs no earlier than the cycle after the result handshake.
// - DONE: sum/cout/out_valid held stable until out_ready=1 (any backpressure).
// - sum bits of unprocessed nibbles read 0 while in RUN.
// - WIDTH%4!=0 or WIDTH<4: elaboration-time error via generate-block check.
//
// CONFIGURATION
// CLA_SUB_EN defined: extra input port sub (1 bit, sampled at accept). sub=1
//   computes a-b: b is inverted per nibble, initial carry forced to 1, cin is
//   ignored; cout=1 means no borrow (a>=b unsigned). sub=0 behaves as add.
// CLA_SUB_EN undefined: no sub port; add-only behaviour as above.
//
// TESTING (WIDTH=16, NIBBLES=4)
// 1. a=0000,b=0000,cin=0 -> out_valid 4 edges after accept, sum=0000, cout=0.
// 2. a=FFFF,b=0001,cin=0 -> carry ripples all nibbles: sum=0000, cout=1.
// 3. a=AAAA,b=5555,cin=1 -> sum=0000, cout=1; then a=1234,b=4321,cin=0 ->
//    sum=5555, cout=0 (back-to-back, accept on cycle after first handshake).
// 4. Backpressure: out_ready=0 for 6 cycles in DONE, in_valid=1 with new
//    operands -> sum/cout stable, in_ready=0, new operands not taken.
// 5. rst_n=0 for one edge at idx=2 -> next cycle IDLE, sum=0, cout=0,
//    out_valid=0, in_ready=1; following add a=0003,b=0004 -> sum=0007.
// 6. CLA_SUB_EN: sub=1,a=0005,b=0007 -> sum=FFFE, cout=0; a=0007,b=0005 ->
//    sum=0002, cout=1; undefined build elaborates without sub port.

Source files
------------

// File: rtl/cla_nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder controller.
// With CLA_SUB_EN defined, the bundle also carries the subtract select.
interface cla_nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
    // The source keeps valid and its payload stable until that edge.
`ifdef CLA_SUB_EN
    logic             sub;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/cla_nibble_serial_adder_ctrl.sv
// Runs one 4-bit carry-look-ahead slice over WIDTH-bit operands, one nibble per clock, LSB first.
// Define CLA_SUB_EN to add a subtract mode (a - b) selected by the sampled sub bit.
module cla_nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cla_nibble_serial_adder_ctrl_if.slave bus,
    output logic [1:0]                    dbg_state
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("cla_nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDXW-1:0]   idx;
    logic              carry_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;
    logic              accept;
    logic              last_nib;
    logic              init_carry;
    logic [IDXW+1:0]   bit_base;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [3:0]        g;
    logic [3:0]        p;
    logic [3:0]        s;
    logic [4:0]        c;

`ifdef CLA_SUB_EN
    logic              sub_reg;
`endif

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_nib  = (idx == LAST_IDX);
    assign dbg_state = state;
    assign bus.sum   = sum_reg;
    assign bus.cout  = cout_reg;

    // Subtraction is a + ~b + 1, so the first carry is forced high and cin is ignored.
`ifdef CLA_SUB_EN
    assign init_carry = bus.sub ? 1'b1 : bus.cin;
`else
    assign init_carry = bus.cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_nib) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Nibble slice: operands picked by idx, four-level look-ahead carries.
    always_comb begin
        bit_base = {idx, 2'b00};
        a_nib    = a_reg[bit_base +: 4];
`ifdef CLA_SUB_EN
        b_nib    = sub_reg ? ~b_reg[bit_base +: 4] : b_reg[bit_base +: 4];
`else
        b_nib    = b_reg[bit_base +: 4];
`endif
        g    = a_nib & b_nib;
        p    = a_nib ^ b_nib;
        c[0] = carry_reg;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef CLA_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_reg     <= bus.a;
                b_reg     <= bus.b;
                carry_reg <= init_carry;
                idx       <= '0;
                sum_reg   <= '0;
`ifdef CLA_SUB_EN
                sub_reg   <= bus.sub;
`endif
            end else if (state == RUN) begin
                sum_reg[bit_base +: 4] <= s;
                carry_reg              <= c[4];
                idx                    <= idx + 1'b1;
                if (last_nib) begin
                    cout_reg <= c[4];
                end
            end
        end
    end
endmodule
